run_ctrl: RTL and testbench
===========================

// Module: run_ctrl
// PURPOSE
//  Run-control sequencer for the single-cycle CPU. Owns the halt flag and the core enable (cpu_en).
//  Merges halt sources (software MMIO halt store, debug halt request, cycle-budget timeout) and
//  debug resume/single-step requests into one FSM. Sits between the MMIO decoder/debug port and
//  the PC/regfile/memory write enables.
// PARAMETERS
//  CNT_W          32  width of the enabled-cycle counter
//  TIMEOUT_CYCLES 0   halt after this many enabled cycles since the last clear; 0 = timeout disabled
//  START_HALTED   0   1: leave reset in HALTED instead of RUN
// PORTS
//  clk            in   1      clock, all state updates on rising edge
//  rst_n          in   1      asynchronous reset, active low
//  mmio_w_en      in   1      MMIO store to the halt register this cycle
//  mmio_w_data    in   1      bit 0 of that store; 1 = halt
//  dbg_halt_req   in   1      debug halt request, level, held until dbg_ack
//  dbg_resume_req in   1      debug resume request, level, held until dbg_ack
//  dbg_step_req   in   1      debug single-step request, level, held until dbg_ack
//  dbg_cnt_clr    in   1      synchronous clear of cycle_cnt
//  cpu_en         out  1      core advances PC / commits writes this cycle
//  halt           out  1      core is in HALTED
//  halt_cause     out  2      00 none, 01 software, 10 debug, 11 timeout
//  dbg_ack        out  1      one-cycle pulse: a debug request was accepted
//  cycle_cnt      out  CNT_W  number of cycles with cpu_en=1 since reset/clear, wraps
// BEHAVIOUR
//  - States: RUN, HALTED, STEP. cpu_en = (RUN|STEP); halt = (HALTED). Both are decoded from the
//    state register only, with no combinational path from the inputs.
//  - Reset: state = START_HALTED ? HALTED : RUN. halt_cause = 00, dbg_ack = 0, cycle_cnt = 0.
//  - mmio_w_en is honoured only when cpu_en=1. It is ignored in HALTED.
//  - A halting instruction completes normally. halt rises, and cpu_en falls, on the next edge
//    (latency 1).
//  - RUN, priority high to low:
//    1. mmio_w_en & mmio_w_data -> HALTED, cause 01.
//    2. dbg_halt_req -> HALTED, cause 10, ack.
//    3. TIMEOUT_CYCLES != 0 and cycle_cnt == TIMEOUT_CYCLES-1 -> HALTED, cause 11.
//    4. dbg_resume_req or dbg_step_req -> acked as a no-op, stay in RUN.
//    mmio_w_en with mmio_w_data=0 has no effect.
//  - HALTED:
//    - dbg_resume_req -> RUN, cause 00, ack.
//    - else dbg_step_req -> STEP, ack.
//    - else dbg_halt_req -> acked as a no-op.
//    - Resume wins over step when both are asserted.
//  - STEP lasts exactly one cycle (cpu_en=1), then always goes to HALTED. The cause becomes 01 if
//    the stepped instruction performs the MMIO halt store, else 10. Debug requests are not sampled
//    in STEP.
//  - Handshake: a request is sampled only while dbg_ack=0. dbg_ack is registered and rises in the
//    cycle after acceptance. The requester drops its request on seeing dbg_ack. This gives one
//    acceptance per request, and ack-to-next-request costs at least 1 idle cycle.
//  - Simultaneous debug requests in RUN: halt > resume/step.
//  - cycle_cnt: dbg_cnt_clr -> 0, which takes priority over the increment. Otherwise it adds 1 in
//    every cpu_en=1 cycle, and wraps modulo 2^CNT_W. The timeout compare uses the pre-increment
//    value, so the halt comes after exactly TIMEOUT_CYCLES enabled cycles.
//  - The timeout is not sticky. After a resume, the count continues past TIMEOUT_CYCLES and does
//    not re-fire until a clear or a wrap. A clear in the same cycle as a timeout match still halts.
//  - halt_cause holds its value in HALTED and is cleared only by a resume or a reset.
//  - Async reset mid-STEP or mid-handshake: the block returns to its reset state and dbg_ack is
//    dropped immediately.
// TESTING
//  1. Reset release, START_HALTED=0:
//     - halt=0, cpu_en=1, cause=00.
//     - MMIO store of 1 at cycle 5 -> halt=1 at cycle 6, cause=01, cycle_cnt=6.
//  2. dbg_halt_req held in RUN:
//     - dbg_ack pulses once, halt=1, cause=10.
//     - A same-cycle MMIO halt store -> cause=01 instead.
//  3. From HALTED, dbg_step_req:
//     - ack, then exactly 1 cycle with cpu_en=1, then halt=1, and cycle_cnt advances by 1.
//     - Resume+step together -> RUN, cause=00.
//  4. TIMEOUT_CYCLES=10:
//     - halt=1 with cause=11 after exactly 10 enabled cycles.
//     - Resume -> no re-halt for a further 100 cycles.
//  5. In HALTED, MMIO store of 1 -> ignored, and cycle_cnt stays frozen.
//     dbg_cnt_clr -> cycle_cnt=0 next cycle.
//  6. Assert rst_n low during STEP -> immediately cpu_en=1, halt=0, ack=0, cnt=0.

Source files
------------

// File: rtl/run_ctrl_if.sv
// Run-control bundle: MMIO halt store and debug requests in, core enable and halt status out.
interface run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             mmio_w_en;
    logic             mmio_w_data;
    logic             dbg_halt_req;
    logic             dbg_resume_req;
    logic             dbg_step_req;
    logic             dbg_cnt_clr;
    logic             cpu_en;
    logic             halt;
    logic [1:0]       halt_cause;
    logic             dbg_ack;
    logic [CNT_W-1:0] cycle_cnt;

    modport slave (
        input  mmio_w_en, mmio_w_data, dbg_halt_req, dbg_resume_req, dbg_step_req, dbg_cnt_clr,
        output cpu_en, halt, halt_cause, dbg_ack, cycle_cnt
    );

    modport master (
        output mmio_w_en, mmio_w_data, dbg_halt_req, dbg_resume_req, dbg_step_req, dbg_cnt_clr,
        input  cpu_en, halt, halt_cause, dbg_ack, cycle_cnt
    );
endinterface

// File: rtl/run_ctrl.sv
// Run-control sequencer: merges software, debug and cycle-budget halt sources into one FSM
// that owns the core enable, the halt flag and the enabled-cycle counter.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_RUN    | core enabled, all halt sources and debug requests sampled
//   S_HALTED | core frozen, waiting for debug resume or single-step
//   S_STEP   | exactly one enabled cycle, then back to S_HALTED
module run_ctrl #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 0,
    parameter bit START_HALTED   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    run_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_STEP   = 2'd2
    } state_t;

    localparam state_t           RST_STATE = START_HALTED ? S_HALTED : S_RUN;
    localparam bit               TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_MATCH  = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_SW   = 2'b01;
    localparam logic [1:0] CAUSE_DBG  = 2'b10;
    localparam logic [1:0] CAUSE_TO   = 2'b11;

    state_t           r_state;
    logic [1:0]       r_cause;
    logic             r_ack;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic [1:0]       w_cause_nxt;
    logic             w_ack_nxt;
    logic             w_run;
    logic             w_sw_halt;
    logic             w_timeout;
    logic             w_req_ok;

    assign w_run     = (r_state != S_HALTED);
    assign w_sw_halt = bus.mmio_w_en & bus.mmio_w_data;
    // Pre-increment compare: the halt lands after exactly TIMEOUT_CYCLES enabled cycles.
    assign w_timeout = TO_EN && (r_cnt == TO_MATCH);
    assign w_req_ok  = ~r_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_STATE;
            r_cause <= CAUSE_NONE;
            r_ack   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cause <= w_cause_nxt;
            r_ack   <= w_ack_nxt;
            if (bus.dbg_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_run) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_ack_nxt   = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_sw_halt) begin
                    w_state_nxt = S_HALTED;
                    w_cause_nxt = CAUSE_SW;
                end else if (bus.dbg_halt_req && w_req_ok) begin
                    w_state_nxt = S_HALTED;
                    w_cause_nxt = CAUSE_DBG;
                    w_ack_nxt   = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = S_HALTED;
                    w_cause_nxt = CAUSE_TO;
                end else if ((bus.dbg_resume_req || bus.dbg_step_req) && w_req_ok) begin
                    w_ack_nxt   = 1'b1;
                end
            end
            S_HALTED: begin
                if (w_req_ok) begin
                    if (bus.dbg_resume_req) begin
                        w_state_nxt = S_RUN;
                        w_cause_nxt = CAUSE_NONE;
                        w_ack_nxt   = 1'b1;
                    end else if (bus.dbg_step_req) begin
                        w_state_nxt = S_STEP;
                        w_ack_nxt   = 1'b1;
                    end else if (bus.dbg_halt_req) begin
                        w_ack_nxt   = 1'b1;
                    end
                end
            end
            S_STEP: begin
                w_state_nxt = S_HALTED;
                w_cause_nxt = w_sw_halt ? CAUSE_SW : CAUSE_DBG;
            end
            default: begin
                w_state_nxt = RST_STATE;
            end
        endcase
    end

    always_comb begin
        bus.cpu_en     = w_run;
        bus.halt       = (r_state == S_HALTED);
        bus.halt_cause = r_cause;
        bus.dbg_ack    = r_ack;
        bus.cycle_cnt  = r_cnt;
    end
endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: one instance without timeout (a), one with a 10-cycle budget (b).
module tb_run_ctrl;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    run_ctrl_if #(.CNT_W(32)) ifa ();
    run_ctrl_if #(.CNT_W(32)) ifb ();

    run_ctrl #(.CNT_W(32), .TIMEOUT_CYCLES(0), .START_HALTED(1'b0)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    run_ctrl #(.CNT_W(32), .TIMEOUT_CYCLES(10), .START_HALTED(1'b0)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic en, input logic h, input logic [1:0] cause,
                         input logic ack, input logic [31:0] cnt);
        chk({tag, "_cpu_en"}, 32'(ifa.cpu_en), 32'(en));
        chk({tag, "_halt"},   32'(ifa.halt), 32'(h));
        chk({tag, "_cause"},  32'(ifa.halt_cause), 32'(cause));
        chk({tag, "_ack"},    32'(ifa.dbg_ack), 32'(ack));
        chk({tag, "_cnt"},    ifa.cycle_cnt, cnt);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        {ifa.mmio_w_en, ifa.mmio_w_data, ifa.dbg_halt_req, ifa.dbg_resume_req,
         ifa.dbg_step_req, ifa.dbg_cnt_clr} = '0;
        {ifb.mmio_w_en, ifb.mmio_w_data, ifb.dbg_halt_req, ifb.dbg_resume_req,
         ifb.dbg_step_req, ifb.dbg_cnt_clr} = '0;
        tick();
        tick();
        chk_a("rst", 1'b1, 1'b0, 2'b00, 1'b0, 32'd0);
        chk("rst_b_halt", 32'(ifb.halt), 32'd0);

        // software halt store in the cycle where cnt=5
        rst_n = 1'b1;
        repeat (5) tick();
        chk_a("run5", 1'b1, 1'b0, 2'b00, 1'b0, 32'd5);
        ifa.mmio_w_en = 1'b1; ifa.mmio_w_data = 1'b1;
        tick();
        ifa.mmio_w_en = 1'b0; ifa.mmio_w_data = 1'b0;
        chk_a("sw_halt", 1'b0, 1'b1, 2'b01, 1'b0, 32'd6);

        // budget of 10 enabled cycles on instance b
        repeat (3) tick();
        chk("to_b_halt9", 32'(ifb.halt), 32'd0);
        chk("to_b_cnt9", ifb.cycle_cnt, 32'd9);
        tick();
        chk("to_b_halt10", 32'(ifb.halt), 32'd1);
        chk("to_b_cause10", 32'(ifb.halt_cause), 32'd3);
        chk("to_b_cnt10", ifb.cycle_cnt, 32'd10);
        chk("to_b_cpu_en10", 32'(ifb.cpu_en), 32'd0);
        chk("frozen_a_cnt", ifa.cycle_cnt, 32'd6);

        // halted: MMIO store ignored, counter frozen, clear works
        ifa.mmio_w_en = 1'b1; ifa.mmio_w_data = 1'b1;
        tick();
        ifa.mmio_w_en = 1'b0; ifa.mmio_w_data = 1'b0;
        chk_a("halted_mmio", 1'b0, 1'b1, 2'b01, 1'b0, 32'd6);
        ifa.dbg_cnt_clr = 1'b1;
        tick();
        ifa.dbg_cnt_clr = 1'b0;
        chk("clr_cnt", ifa.cycle_cnt, 32'd0);
        tick();
        chk("clr_cnt_hold", ifa.cycle_cnt, 32'd0);

        // resume b: timeout must not re-fire while counting past 10
        ifb.dbg_resume_req = 1'b1;
        tick();
        ifb.dbg_resume_req = 1'b0;
        chk("b_res_ack", 32'(ifb.dbg_ack), 32'd1);
        chk("b_res_halt", 32'(ifb.halt), 32'd0);
        chk("b_res_cause", 32'(ifb.halt_cause), 32'd0);
        chk("b_res_cnt", ifb.cycle_cnt, 32'd10);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("b_no_rehalt", 32'(ifb.halt), 32'd0);
        end
        chk("b_cnt110", ifb.cycle_cnt, 32'd110);
        chk("b_ack_low", 32'(ifb.dbg_ack), 32'd0);

        // debug halt in RUN, ack pulses once
        ifa.dbg_resume_req = 1'b1;
        tick();
        ifa.dbg_resume_req = 1'b0;
        chk_a("a_res", 1'b1, 1'b0, 2'b00, 1'b1, 32'd0);
        tick();
        chk_a("a_res_idle", 1'b1, 1'b0, 2'b00, 1'b0, 32'd1);
        ifa.dbg_halt_req = 1'b1;
        tick();
        ifa.dbg_halt_req = 1'b0;
        chk_a("dbg_halt", 1'b0, 1'b1, 2'b10, 1'b1, 32'd2);
        tick();
        chk_a("dbg_halt_idle", 1'b0, 1'b1, 2'b10, 1'b0, 32'd2);

        // same-cycle MMIO store beats debug halt
        ifa.dbg_resume_req = 1'b1;
        tick();
        ifa.dbg_resume_req = 1'b0;
        tick();
        chk_a("a_res2", 1'b1, 1'b0, 2'b00, 1'b0, 32'd3);
        ifa.dbg_halt_req = 1'b1; ifa.mmio_w_en = 1'b1; ifa.mmio_w_data = 1'b1;
        tick();
        ifa.mmio_w_en = 1'b0; ifa.mmio_w_data = 1'b0;
        chk_a("sw_beats_dbg", 1'b0, 1'b1, 2'b01, 1'b0, 32'd4);
        tick();
        ifa.dbg_halt_req = 1'b0;
        chk_a("halted_halt_noop", 1'b0, 1'b1, 2'b01, 1'b1, 32'd4);
        tick();
        chk_a("halted_idle", 1'b0, 1'b1, 2'b01, 1'b0, 32'd4);

        // single step
        ifa.dbg_step_req = 1'b1;
        tick();
        ifa.dbg_step_req = 1'b0;
        chk_a("step", 1'b1, 1'b0, 2'b01, 1'b1, 32'd4);
        tick();
        chk_a("step_done", 1'b0, 1'b1, 2'b10, 1'b0, 32'd5);
        ifa.dbg_step_req = 1'b1;
        tick();
        ifa.dbg_step_req = 1'b0;
        ifa.mmio_w_en = 1'b1; ifa.mmio_w_data = 1'b1;
        tick();
        ifa.mmio_w_en = 1'b0; ifa.mmio_w_data = 1'b0;
        chk_a("step_sw", 1'b0, 1'b1, 2'b01, 1'b0, 32'd6);

        // resume wins over step
        ifa.dbg_resume_req = 1'b1; ifa.dbg_step_req = 1'b1;
        tick();
        ifa.dbg_resume_req = 1'b0; ifa.dbg_step_req = 1'b0;
        chk_a("res_over_step", 1'b1, 1'b0, 2'b00, 1'b1, 32'd6);
        tick();
        chk("res_over_step_cnt", ifa.cycle_cnt, 32'd7);

        // step request in RUN is acked as a no-op
        ifa.dbg_step_req = 1'b1;
        tick();
        ifa.dbg_step_req = 1'b0;
        chk_a("run_step_noop", 1'b1, 1'b0, 2'b00, 1'b1, 32'd8);
        tick();

        // async reset while in STEP
        ifa.dbg_halt_req = 1'b1;
        tick();
        ifa.dbg_halt_req = 1'b0;
        chk_a("halt_pre_rst", 1'b0, 1'b1, 2'b10, 1'b1, 32'd10);
        tick();
        ifa.dbg_step_req = 1'b1;
        tick();
        ifa.dbg_step_req = 1'b0;
        chk_a("step_pre_rst", 1'b1, 1'b0, 2'b10, 1'b1, 32'd10);
        rst_n = 1'b0;
        #1;
        chk_a("rst_in_step", 1'b1, 1'b0, 2'b00, 1'b0, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_cnt", ifa.cycle_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
